ct_idu_id_split_amo: RTL
========================

Name: ct_idu_id_split_amo

Overview:
Consumer-side counterpart of the ID special decoder. It takes an instruction that the decoder flagged as atomic long-split (split_long_type[0]: amswap/amadd/amand/amor/amxor/ammax/ammin[.wu/.du], plain and _db) and expands it into a serial micro-op stream: optional pre-barrier, load, ALU, store, optional register move and optional post-barrier. It sits between ID decode and IR rename. It stalls ID while expanding and hands one uop per accepted cycle to IR under a valid/ready handshake.

Parameters:
TMP0_IDX, 6'd32, internal temp register receiving the loaded (old) memory value
TMP1_IDX, 6'd33, internal temp register receiving the ALU result that is stored

Ports:
forever_cpuclk  in  1  core clock
cpurst  in  1  synchronous active-high reset
rtu_idu_flush  in  1  pipeline flush; abort any expansion
id_inst_vld  in  1  ID offers an instruction
id_split_amo  in  1  decoder's split_long_type[0] for id_inst
id_inst  in  32  raw instruction
split_id_rdy  out  1  block can accept (IDLE)
split_ir_uop_vld  out  1  uop valid to IR
ir_split_uop_rdy  in  1  IR accepts uop
split_ir_uop_type  out  3  0 FENCE, 1 LD, 2 ALU, 3 ST, 4 MOV, 7 EXCP
split_ir_uop_alu_op  out  4  0 swap(pass rk), 1 add, 2 and, 3 or, 4 xor, 5 max, 6 min, 7 maxu, 8 minu
split_ir_uop_dword  out  1  1 = .d, 0 = .w
split_ir_uop_dst  out  6  destination register index
split_ir_uop_src0  out  6  source 0 / address register
split_ir_uop_src1  out  6  source 1
split_ir_uop_first  out  1  first uop of the instruction
split_ir_uop_last  out  1  last uop of the instruction

Behaviour:
- Field decode on capture: code = inst[20:15] (6 bits); legal only when inst[31:21] = 11'b00111000011 and code <= 35. dword = code[0]; db = (code >= 18); alu_op = (code mod 18) >> 1; rd = inst[4:0], rj = inst[9:5], rk = inst[14:10], each zero-extended to 6 bits.
- States: IDLE, PRE_FENCE, LD, ALU, ST, MOV, POST_FENCE, EXCP.
- IDLE: split_id_rdy = 1. On id_inst_vld & id_split_amo & !flush, capture the instruction.
  - Legal code: go to PRE_FENCE if db, otherwise LD.
  - Illegal code: go to EXCP.
  - id_split_amo = 0: ignored; no capture.
- A non-IDLE state drives uop_vld = 1 and advances only on vld & rdy. Outputs hold stable while rdy = 0.
- Uop fields per state:
  - PRE_FENCE: FENCE.
  - LD: dst = TMP0, src0 = rj.
  - ALU: dst = TMP1, src0 = TMP0, src1 = rk.
  - ST: src0 = rj, src1 = TMP1.
  - MOV: dst = rd, src0 = TMP0.
  - POST_FENCE: FENCE.
  - EXCP: single uop, first = last = 1.
  - Unused dst/src fields drive 0.
- Transitions:
  - PRE_FENCE -> LD -> ALU -> ST.
  - ST -> MOV if rd != 0; else POST_FENCE if db; else IDLE.
  - MOV -> POST_FENCE if db, else IDLE.
  - POST_FENCE -> IDLE. EXCP -> IDLE.
- Marking: first = 1 on the first emitted state. last = 1 on the final state of the sequence. Sequence length ranges from 3 (plain, rd = 0) to 6 (db, rd != 0).
- Latency: capture cycle N, first uop valid in N+1. With IR always ready, a new instruction is accepted one cycle after the last uop handshake; no back-to-back bypass.
- Flush: rtu_idu_flush forces IDLE the next cycle and drops vld the same cycle, including mid-sequence and during a stall. A flush in IDLE blocks capture. Flush has priority over handshake and capture.
- Reset: state = IDLE, and all outputs are 0 except split_id_rdy = 1. Captured fields reset to 0.

Decomposition:
- Shared package ct_idu_split_pkg holds:
  - uop type encodings and alu_op encodings;
  - state encoding;
  - AMO prefix constant 11'b00111000011 and max code 35.
- One natural sub-module, ct_idu_split_amo_fdecd: purely combinational field decode (legal, db, dword, alu_op, regs) from the inst.
- The FSM and output mux stay in the top module.

Test Plan:
- amadd.w rd=3, rj=4, rk=5 (code 2), IR always ready -> 4 uops on consecutive cycles:
  - LD(dst 32, src0 4), first = 1;
  - ALU(op 1, dst 33, src 32/5);
  - ST(src0 4, src1 33);
  - MOV(dst 3, src0 32), last = 1.
  - dword = 0 throughout; split_id_rdy returns to 1 the next cycle.
- ammin_db.du rd=0 (code 35) -> FENCE(first), LD, ALU(op 8), ST, FENCE(last); dword = 1; no MOV.
- amswap.d rd=0 with ir_split_uop_rdy toggled 1,0,0,1,... -> each uop held stable while rdy = 0; exactly 3 handshakes; alu_op = 0.
- Flush asserted in the ALU state during an IR stall -> vld drops that cycle, IDLE next cycle; a subsequent amor.w expands normally from LD.
- id_split_amo = 1 with inst[20:15] = 36 -> single EXCP uop with first = last = 1; id_split_amo = 0 with any inst -> no uop, rdy stays 1.
- cpurst asserted mid-sequence (ST state) -> next cycle state IDLE, vld = 0, split_id_rdy = 1.

Source files
------------

// File: rtl/ct_idu_split_pkg.sv
// Shared encodings for the atomic long-split expander: uop types, ALU ops,
// FSM states, the AMO opcode prefix and the decoded-field bundle.
package ct_idu_split_pkg;

  // uop types presented to IR
  localparam logic [2:0] UOP_FENCE = 3'd0;
  localparam logic [2:0] UOP_LD    = 3'd1;
  localparam logic [2:0] UOP_ALU   = 3'd2;
  localparam logic [2:0] UOP_ST    = 3'd3;
  localparam logic [2:0] UOP_MOV   = 3'd4;
  localparam logic [2:0] UOP_EXCP  = 3'd7;

  // ALU operations carried by the ALU uop
  localparam logic [3:0] ALU_SWAP  = 4'd0;
  localparam logic [3:0] ALU_ADD   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_MAX   = 4'd5;
  localparam logic [3:0] ALU_MIN   = 4'd6;
  localparam logic [3:0] ALU_MAXU  = 4'd7;
  localparam logic [3:0] ALU_MINU  = 4'd8;

  // expander FSM states
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PRE_FENCE  = 3'd1;
  localparam logic [2:0] S_LD         = 3'd2;
  localparam logic [2:0] S_ALU        = 3'd3;
  localparam logic [2:0] S_ST         = 3'd4;
  localparam logic [2:0] S_MOV        = 3'd5;
  localparam logic [2:0] S_POST_FENCE = 3'd6;
  localparam logic [2:0] S_EXCP       = 3'd7;

  // AMO opcode space: fixed prefix in inst[31:21], codes 0..35 in inst[20:15]
  localparam logic [10:0] AMO_PREFIX   = 11'b00111000011;
  localparam logic [5:0]  AMO_MAX_CODE = 6'd35;
  localparam logic [5:0]  AMO_DB_BASE  = 6'd18;

  // internal temporaries holding the old memory value and the ALU result
  localparam logic [5:0] TMP0_IDX_DEF = 6'd32;
  localparam logic [5:0] TMP1_IDX_DEF = 6'd33;

  typedef struct packed {
    logic       legal;
    logic       db;
    logic       dword;
    logic [3:0] alu_op;
    logic [5:0] rd;
    logic [5:0] rj;
    logic [5:0] rk;
  } amo_fields_t;

endpackage

// File: rtl/ct_idu_split_amo_fdecd.sv
// Combinational field decode of an AMO instruction: legality, barrier
// flavour, operand width, ALU op and the three architectural registers.
module ct_idu_split_amo_fdecd
  import ct_idu_split_pkg::*;
(
  input  logic [31:0]  inst,
  output amo_fields_t  fields
);

  logic [5:0] code;
  logic [5:0] code_base;

  // the _db variants repeat the plain table 18 codes higher
  always_comb begin
    code          = inst[20:15];
    code_base     = (code >= AMO_DB_BASE) ? (code - AMO_DB_BASE) : code;
    fields        = '0;
    fields.legal  = (inst[31:21] == AMO_PREFIX) && (code <= AMO_MAX_CODE);
    fields.db     = (code >= AMO_DB_BASE);
    fields.dword  = code[0];
    fields.alu_op = 4'(code_base >> 1);
    fields.rd     = {1'b0, inst[4:0]};
    fields.rj     = {1'b0, inst[9:5]};
    fields.rk     = {1'b0, inst[14:10]};
  end

endmodule

// File: rtl/ct_idu_id_split_amo.sv
// Atomic long-split expander between ID decode and IR rename. Captures one
// AMO and emits its barrier/load/ALU/store/move uops one per IR handshake.
module ct_idu_id_split_amo
  import ct_idu_split_pkg::*;
#(
  parameter logic [5:0] TMP0_IDX = TMP0_IDX_DEF,
  parameter logic [5:0] TMP1_IDX = TMP1_IDX_DEF
)
(
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        rtu_idu_flush,
  input  logic        id_inst_vld,
  input  logic        id_split_amo,
  input  logic [31:0] id_inst,
  output logic        split_id_rdy,
  output logic        split_ir_uop_vld,
  input  logic        ir_split_uop_rdy,
  output logic [2:0]  split_ir_uop_type,
  output logic [3:0]  split_ir_uop_alu_op,
  output logic        split_ir_uop_dword,
  output logic [5:0]  split_ir_uop_dst,
  output logic [5:0]  split_ir_uop_src0,
  output logic [5:0]  split_ir_uop_src1,
  output logic        split_ir_uop_first,
  output logic        split_ir_uop_last
);

  amo_fields_t dec;
  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        cap_db;
  logic        cap_dword;
  logic [3:0]  cap_alu_op;
  logic [5:0]  cap_rd;
  logic [5:0]  cap_rj;
  logic [5:0]  cap_rk;
  logic        capture;
  logic        handshake;
  logic        rd_nz;

  ct_idu_split_amo_fdecd u_fdecd (
    .inst   (id_inst),
    .fields (dec)
  );

  assign capture   = (state == S_IDLE) && id_inst_vld && id_split_amo && !rtu_idu_flush;
  assign handshake = split_ir_uop_vld && ir_split_uop_rdy;
  assign rd_nz     = (cap_rd != 6'd0);

  // sequence walk; a flush overrides any handshake or capture
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (capture)   state_nxt = !dec.legal ? S_EXCP :
                                               (dec.db ? S_PRE_FENCE : S_LD);
      S_PRE_FENCE:  if (handshake) state_nxt = S_LD;
      S_LD:         if (handshake) state_nxt = S_ALU;
      S_ALU:        if (handshake) state_nxt = S_ST;
      S_ST:         if (handshake) state_nxt = rd_nz ? S_MOV :
                                               (cap_db ? S_POST_FENCE : S_IDLE);
      S_MOV:        if (handshake) state_nxt = cap_db ? S_POST_FENCE : S_IDLE;
      S_POST_FENCE: if (handshake) state_nxt = S_IDLE;
      S_EXCP:       if (handshake) state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
    if (rtu_idu_flush) state_nxt = S_IDLE;
  end

  // state register plus the fields latched when an instruction is taken
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state      <= S_IDLE;
      cap_db     <= 1'b0;
      cap_dword  <= 1'b0;
      cap_alu_op <= 4'd0;
      cap_rd     <= 6'd0;
      cap_rj     <= 6'd0;
      cap_rk     <= 6'd0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cap_db     <= dec.db;
        cap_dword  <= dec.dword;
        cap_alu_op <= dec.alu_op;
        cap_rd     <= dec.rd;
        cap_rj     <= dec.rj;
        cap_rk     <= dec.rk;
      end
    end
  end

  // per-state uop fields; idle and unused fields stay at zero
  always_comb begin
    split_id_rdy        = (state == S_IDLE);
    split_ir_uop_vld    = (state != S_IDLE) && !rtu_idu_flush;
    split_ir_uop_type   = UOP_FENCE;
    split_ir_uop_alu_op = ALU_SWAP;
    split_ir_uop_dword  = 1'b0;
    split_ir_uop_dst    = 6'd0;
    split_ir_uop_src0   = 6'd0;
    split_ir_uop_src1   = 6'd0;
    split_ir_uop_first  = 1'b0;
    split_ir_uop_last   = 1'b0;
    case (state)
      S_PRE_FENCE: begin
        split_ir_uop_type  = UOP_FENCE;
        split_ir_uop_dword = cap_dword;
        split_ir_uop_first = 1'b1;
      end
      S_LD: begin
        split_ir_uop_type  = UOP_LD;
        split_ir_uop_dword = cap_dword;
        split_ir_uop_dst   = TMP0_IDX;
        split_ir_uop_src0  = cap_rj;
        split_ir_uop_first = !cap_db;
      end
      S_ALU: begin
        split_ir_uop_type   = UOP_ALU;
        split_ir_uop_alu_op = cap_alu_op;
        split_ir_uop_dword  = cap_dword;
        split_ir_uop_dst    = TMP1_IDX;
        split_ir_uop_src0   = TMP0_IDX;
        split_ir_uop_src1   = cap_rk;
      end
      S_ST: begin
        split_ir_uop_type  = UOP_ST;
        split_ir_uop_dword = cap_dword;
        split_ir_uop_src0  = cap_rj;
        split_ir_uop_src1  = TMP1_IDX;
        split_ir_uop_last  = !rd_nz && !cap_db;
      end
      S_MOV: begin
        split_ir_uop_type  = UOP_MOV;
        split_ir_uop_dword = cap_dword;
        split_ir_uop_dst   = cap_rd;
        split_ir_uop_src0  = TMP0_IDX;
        split_ir_uop_last  = !cap_db;
      end
      S_POST_FENCE: begin
        split_ir_uop_type  = UOP_FENCE;
        split_ir_uop_dword = cap_dword;
        split_ir_uop_last  = 1'b1;
      end
      S_EXCP: begin
        split_ir_uop_type  = UOP_EXCP;
        split_ir_uop_first = 1'b1;
        split_ir_uop_last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
